// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: shared state encoding, instruction classes and ALU constants for the ARM control FSM
package arm_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_e;
  typedef enum logic [1:0] {
    CLS_DP  = 2'd0,
    CLS_LS  = 2'd1,
    CLS_BR  = 2'd2,
    CLS_UND = 2'd3
  } cls_e;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] CMP_LO  = 4'b1000;
  localparam logic [3:0] CMP_HI  = 4'b1011;
  function automatic logic is_cmp(input logic [3:0] op);
    return op >= CMP_LO && op <= CMP_HI;
  endfunction
endpackage

// File: rtl/arm_ctrl_decode.sv
// arm_ctrl_decode: combinational IR classifier (class, writes_reg, link, load)
module arm_ctrl_decode
  import arm_ctrl_pkg::*;
#(
  parameter int IR_W = 28
) (
  input  logic [IR_W-1:0] ir,
  output cls_e            cls,
  output logic            writes_reg,
  output logic            link,
  output logic            load
);
  logic ir_unused;
  assign ir_unused = ^ir[19:0];
  always_comb begin
    cls = ir[27:26] == 2'b00 ? CLS_DP :
          ir[27:26] == 2'b01 ? CLS_LS :
          ir[27:25] == 3'b101 ? CLS_BR : CLS_UND;
    link = cls == CLS_BR && ir[24];
    load = cls == CLS_LS && ir[20];
    writes_reg = (cls == CLS_DP && !is_cmp(ir[24:21])) || load || link;
  end
endmodule

// File: rtl/arm_ctrl_fsm.sv
// arm_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit with Moore strobes.
// Optional retired-instruction counter enabled by ARM_CTRL_RETIRE_CNT_EN.
module arm_ctrl_fsm
  import arm_ctrl_pkg::*;
#(
  parameter int IR_W  = 28,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic [IR_W-1:0]  IR,
  input  logic             flag,
  input  logic             Mem_Ready,
  output logic             Write_IR,
  output logic             Write_PC,
  output logic             PC_sel,
  output logic             Write_Reg,
  output logic             Link,
  output logic             Write_NZCV,
  output logic [3:0]       ALU_OP,
  output logic             Mem_Read,
  output logic             Mem_Write,
  output logic             Undef,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] Retired
);
  state_e     state_q, state_d;
  cls_e       cls_q, cls_d, dec_cls;
  logic       wr_q, wr_d, lnk_q, lnk_d, ld_q, ld_d, nz_q, nz_d, und_q, und_d;
  logic [3:0] alu_q, alu_d;
  logic       dec_wr, dec_lnk, dec_ld;
  arm_ctrl_decode #(.IR_W(IR_W)) u_dec (
    .ir        (IR),
    .cls       (dec_cls),
    .writes_reg(dec_wr),
    .link      (dec_lnk),
    .load      (dec_ld)
  );
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    wr_d       = wr_q;
    lnk_d      = lnk_q;
    ld_d       = ld_q;
    nz_d       = nz_q;
    alu_d      = alu_q;
    und_d      = 1'b0;
    Write_IR   = 1'b0;
    Write_PC   = 1'b0;
    PC_sel     = 1'b0;
    Write_Reg  = 1'b0;
    Link       = 1'b0;
    Write_NZCV = 1'b0;
    ALU_OP     = 4'b0000;
    Mem_Read   = 1'b0;
    Mem_Write  = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        Write_IR = 1'b1;
        Write_PC = 1'b1;
        state_d  = DECODE;
      end
      DECODE: begin
        cls_d   = dec_cls;
        wr_d    = dec_wr;
        lnk_d   = dec_lnk;
        ld_d    = dec_ld;
        nz_d    = dec_cls == CLS_DP && IR[20];
        alu_d   = dec_cls == CLS_DP ? IR[24:21] :
                  (dec_cls == CLS_LS && !IR[23]) ? ALU_SUB : ALU_ADD;
        und_d   = flag && dec_cls == CLS_UND;
        state_d = (flag && dec_cls != CLS_UND) ? EXEC : FETCH;
      end
      EXEC: begin
        ALU_OP     = alu_q;
        Write_NZCV = nz_q;
        Write_PC   = cls_q == CLS_BR;
        PC_sel     = cls_q == CLS_BR;
        state_d    = cls_q == CLS_LS ? MEM : wr_q ? WB : FETCH;
      end
      MEM: begin
        Mem_Read  = ld_q;
        Mem_Write = !ld_q;
        state_d   = !Mem_Ready ? MEM : ld_q ? WB : FETCH;
      end
      WB: begin
        Write_Reg = 1'b1;
        Link      = lnk_q;
        state_d   = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cls_q   <= CLS_DP;
      wr_q    <= 1'b0;
      lnk_q   <= 1'b0;
      ld_q    <= 1'b0;
      nz_q    <= 1'b0;
      und_q   <= 1'b0;
      alu_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wr_q    <= wr_d;
      lnk_q   <= lnk_d;
      ld_q    <= ld_d;
      nz_q    <= nz_d;
      und_q   <= und_d;
      alu_q   <= alu_d;
    end
  end
  // Undef is registered so it pulses during the FETCH that follows the bad DECODE
  assign Undef = und_q;
  assign State = state_q;
`ifdef ARM_CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] ret_q, ret_d;
  always_comb
    ret_d = ret_q + CNT_W'(state_d == FETCH && (state_q == EXEC || state_q == MEM || state_q == WB));
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) ret_q <= '0;
    else ret_q <= ret_d;
  end
  assign Retired = ret_q;
`else
  assign Retired = '0;
`endif
endmodule

// File: tb/tb_arm_ctrl_fsm.sv
// tb_arm_ctrl_fsm: per-instruction timeline model checked cycle by cycle against arm_ctrl_fsm
module tb_arm_ctrl_fsm;
  localparam int IR_W  = 28;
  localparam int CNT_W = 16;
  logic clk = 1'b0;
  logic Rst_n;
  logic [IR_W-1:0] IR;
  logic flag, Mem_Ready;
  logic Write_IR, Write_PC, PC_sel, Write_Reg, Link, Write_NZCV, Mem_Read, Mem_Write, Undef;
  logic [3:0] ALU_OP;
  logic [2:0] State;
  logic [CNT_W-1:0] Retired;
  int checks = 0;
  int errors = 0;
  logic pend_undef = 1'b0;
  int exp_ret = 0;

  arm_ctrl_fsm #(.IR_W(IR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .Rst_n(Rst_n), .IR(IR), .flag(flag), .Mem_Ready(Mem_Ready),
    .Write_IR(Write_IR), .Write_PC(Write_PC), .PC_sel(PC_sel), .Write_Reg(Write_Reg),
    .Link(Link), .Write_NZCV(Write_NZCV), .ALU_OP(ALU_OP), .Mem_Read(Mem_Read),
    .Mem_Write(Mem_Write), .Undef(Undef), .State(State), .Retired(Retired)
  );

  always #5 clk = ~clk;

  // record layout: {state, Write_IR, Write_PC, PC_sel, Write_Reg, Link, Write_NZCV, ALU_OP, Mem_Read, Mem_Write, Undef}
  function automatic logic [15:0] rec(input logic [2:0] st, input logic [5:0] strb,
                                      input logic [3:0] alu, input logic [2:0] mem);
    return {st, strb, alu, mem};
  endfunction

  function automatic logic [15:0] obs();
    return {State, Write_IR, Write_PC, PC_sel, Write_Reg, Link, Write_NZCV, ALU_OP,
            Mem_Read, Mem_Write, Undef};
  endfunction

  function automatic logic [CNT_W-1:0] ret_expect();
`ifdef ARM_CTRL_RETIRE_CNT_EN
    return CNT_W'(exp_ret);
`else
    return '0;
`endif
  endfunction

  // Starts with the DUT in FETCH (1 ns after the edge); ends in the next instruction's FETCH.
  task automatic run_instr(input logic [IR_W-1:0] ir, input logic f, input int waits, input string name);
    logic [15:0] q[$];
    logic [3:0] op;
    logic [15:0] o;
    int nmem;
    nmem = 0;
    IR = ir;
    flag = f;
    q.push_back(rec(3'd1, 6'b110000, 4'd0, {2'b00, pend_undef}));
    q.push_back(rec(3'd2, 6'b000000, 4'd0, 3'b000));
    pend_undef = 1'b0;
    if (f) begin
      if (ir[27:26] == 2'b00) begin
        op = ir[24:21];
        q.push_back(rec(3'd3, {5'b00000, ir[20]}, op, 3'b000));
        if (!(op >= 4'd8 && op <= 4'd11)) q.push_back(rec(3'd5, 6'b000100, 4'd0, 3'b000));
        exp_ret++;
      end else if (ir[27:26] == 2'b01) begin
        q.push_back(rec(3'd3, 6'b000000, ir[23] ? 4'd4 : 4'd2, 3'b000));
        for (int i = 0; i <= waits; i++) q.push_back(rec(3'd4, 6'b000000, 4'd0, {ir[20], ~ir[20], 1'b0}));
        if (ir[20]) q.push_back(rec(3'd5, 6'b000100, 4'd0, 3'b000));
        exp_ret++;
      end else if (ir[27:25] == 3'b101) begin
        q.push_back(rec(3'd3, 6'b011000, 4'd4, 3'b000));
        if (ir[24]) q.push_back(rec(3'd5, 6'b000110, 4'd0, 3'b000));
        exp_ret++;
      end else begin
        pend_undef = 1'b1;
      end
    end
    foreach (q[i]) begin
      if (q[i][15:13] == 3'd4) begin
        Mem_Ready = nmem >= waits;
        nmem++;
      end else begin
        Mem_Ready = 1'($urandom_range(1, 0));
      end
      o = obs();
      checks++;
      if (o !== q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d ir=%h: got %h expected %h", name, i, ir, o, q[i]);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (Retired !== ret_expect()) begin
      errors++;
      $display("FAIL %s retired: got %0d expected %0d", name, Retired, ret_expect());
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    IR = '0;
    flag = 1'b0;
    Mem_Ready = 1'b1;
    #12;
    checks++;
    if (obs() !== 16'h0 || Retired !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %h/%0d expected 0000/0", obs(), Retired);
    end
    Rst_n = 1'b1;
    #1;
    checks++;
    if (obs() !== 16'h0) begin
      errors++;
      $display("FAIL reset_idle: got %h expected 0000", obs());
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== rec(3'd1, 6'b110000, 4'd0, 3'b000)) begin
      errors++;
      $display("FAIL reset_fetch: got %h expected %h", obs(), rec(3'd1, 6'b110000, 4'd0, 3'b000));
    end
  endtask

  task automatic test_dp();
    run_instr(28'h0811002, 1'b1, 0, "dp_add");
    run_instr(28'h1510002, 1'b1, 0, "dp_cmp");
  endtask

  task automatic test_cond_fail();
    run_instr(28'h0811002, 1'b0, 0, "cond_fail");
  endtask

  task automatic test_load_store();
    run_instr(28'h5912000, 1'b1, 3, "ldr_wait3");
    run_instr(28'h5812000, 1'b1, 3, "str_wait3");
    run_instr(28'h5012000, 1'b1, 0, "str_sub");
  endtask

  task automatic test_branch();
    run_instr(28'hA000004, 1'b1, 0, "b");
    run_instr(28'hB000004, 1'b1, 0, "bl");
  endtask

  task automatic test_undef();
    run_instr(28'hF000000, 1'b1, 0, "undef");
    run_instr(28'h8000000, 1'b1, 0, "undef_100");
    run_instr(28'h0811002, 1'b1, 0, "after_undef");
  endtask

  task automatic test_mix();
    logic [CNT_W-1:0] r0, delta, want;
    r0 = Retired;
    run_instr(28'h0811002, 1'b1, 0, "mix_add");
    run_instr(28'h5912000, 1'b1, 1, "mix_ldr");
    run_instr(28'h0811002, 1'b0, 0, "mix_skip");
    run_instr(28'hA000004, 1'b1, 0, "mix_b");
    run_instr(28'hF000000, 1'b1, 0, "mix_undef");
    run_instr(28'h5812000, 1'b1, 2, "mix_str");
`ifdef ARM_CTRL_RETIRE_CNT_EN
    want = 16'd4;
`else
    want = 16'd0;
`endif
    delta = Retired - r0;
    checks++;
    if (delta !== want) begin
      errors++;
      $display("FAIL mix_retired_delta: got %0d expected %0d", delta, want);
    end
  endtask

  task automatic test_random();
    logic [IR_W-1:0] ir;
    int k;
    for (int n = 0; n < 150; n++) begin
      ir = IR_W'($urandom);
      k = int'($urandom_range(4, 0));
      ir[27:25] = k == 0 ? {2'b00, ir[25]} :
                  k == 1 ? {2'b01, ir[25]} :
                  k == 2 ? 3'b101 :
                  k == 3 ? 3'b100 : {2'b11, ir[25]};
      run_instr(ir, $urandom_range(3, 0) != 0, int'($urandom_range(3, 0)), "random");
    end
  endtask

  task automatic test_reset_mid_exec();
    run_instr(28'h0811002, 1'b1, 0, "pre_reset");
    IR = 28'h0811002;
    flag = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (State !== 3'd3) begin
      errors++;
      $display("FAIL mid_exec_reach: got state %0d expected 3", State);
    end
    #2;
    Rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 16'h0 || Retired !== '0) begin
      errors++;
      $display("FAIL mid_exec_abort: got %h/%0d expected 0000/0", obs(), Retired);
    end
    #50;
    Rst_n = 1'b1;
    exp_ret = 0;
    pend_undef = 1'b0;
    #1;
    checks++;
    if (obs() !== 16'h0) begin
      errors++;
      $display("FAIL mid_exec_idle: got %h expected 0000", obs());
    end
    @(posedge clk);
    #1;
    run_instr(28'hB000004, 1'b1, 0, "post_reset_bl");
  endtask

  initial begin
    test_reset();
    test_dp();
    test_cond_fail();
    test_load_store();
    test_branch();
    test_undef();
    test_mix();
    test_random();
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
